// File: rtl/ym_dbg_chain_rx_pkg.sv
// Shared definitions for the debug-chain receiver.
//
// c1/c2 legality: a c1 cycle has c1=1,c2=0 and a c2 cycle has c2=1,c1=0.
// c1=c2=1 in the same cycle is illegal. The receiver then performs only the
// c2 action and ignores c1.
package ym_dbg_chain_rx_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE  = 2'd0,
    DBG_ARMED = 2'd1,
    DBG_SHIFT = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/ym_dbg_chain_rx.sv
// Receiving end of the ym_dbg_read / ym_dbg_read_eg serial debug chains.
// It reassembles a DATA_WIDTH-bit word from the chain's serial output,
// using the same c1 (sample) and c2 (commit) phase enables as the chain.
//
// Ports:
//   MCLK        clock, all state updates on posedge
//   RESET_n     asynchronous active-low reset
//   c1, c2      phase enables shared with the chain
//   load        chain load net, only acted on in c1 cycles
//   serial_in   serial output of the last chain cell
//   data_out    last completed word, held until the next frame completes
//   data_valid  one-cycle strobe when data_out updates
//   busy        a frame is in progress (ARMED or SHIFT)
//   abort       one-cycle strobe when a load restarts an unfinished frame
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DBG_IDLE  | no frame in progress, serial_in ignored
// DBG_ARMED | load seen, waiting for the first committed bit
// DBG_SHIFT | at least one bit committed, frame not yet complete
module ym_dbg_chain_rx
  import ym_dbg_chain_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  MCLK,
  input  logic                  RESET_n,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  load,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  abort
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  dbg_state_e            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  pend_q;
  logic                  samp_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  busy_q;
  logic                  abort_q;

  logic c1_cyc;
  logic c2_cyc;
  logic active;
  logic last_bit;

  // c2 wins when both enables are high, so c1 only counts when c2 is low.
  assign c1_cyc = c1 & ~c2;
  assign c2_cyc = c2;
  assign active = (state_q != DBG_IDLE);

  assign cnt_d    = cnt_q + CNT_W'(1);
  assign last_bit = (cnt_d == CNT_W'(DATA_WIDTH));

  generate
    if (DATA_WIDTH == 1) begin : g_w1
      assign shreg_d = samp_q;
    end else if (MSB_FIRST) begin : g_msb
      assign shreg_d = {shreg_q[DATA_WIDTH-2:0], samp_q};
    end else begin : g_lsb
      assign shreg_d = {samp_q, shreg_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= DBG_IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      samp_q       <= 1'b0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      abort_q      <= 1'b0;
      if (c1_cyc && load) begin
        // Load has priority over sampling and restarts any frame in flight.
        state_q <= DBG_ARMED;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        busy_q  <= 1'b1;
        abort_q <= active;
      end else if (c1_cyc && active) begin
        // A second c1 before the commit simply replaces the sample.
        samp_q <= serial_in;
        pend_q <= 1'b1;
      end else if (c2_cyc && active && pend_q) begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_d;
        pend_q  <= 1'b0;
        if (last_bit) begin
          data_out_q   <= shreg_d;
          data_valid_q <= 1'b1;
          state_q      <= DBG_IDLE;
          busy_q       <= 1'b0;
        end else begin
          state_q <= DBG_SHIFT;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_ym_dbg_chain_rx.sv
module tb_ym_dbg_chain_rx;

  logic       MCLK;
  logic       RESET_n;
  logic       c1;
  logic       c2;
  logic       load;
  logic       serial_in;

  logic [7:0] dout0;
  logic       dv0;
  logic       busy0;
  logic       abort0;
  logic [7:0] dout1;
  logic       dv1;
  logic       busy1;
  logic       abort1;

  int tests    = 0;
  int failures = 0;
  int dv_cnt0  = 0;
  int dv_cnt1  = 0;
  int ab_cnt0  = 0;
  int ab_cnt1  = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] e0;
  logic [7:0] e1;

  ym_dbg_chain_rx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .MCLK(MCLK), .RESET_n(RESET_n), .c1(c1), .c2(c2), .load(load),
    .serial_in(serial_in), .data_out(dout0), .data_valid(dv0),
    .busy(busy0), .abort(abort0)
  );

  ym_dbg_chain_rx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .MCLK(MCLK), .RESET_n(RESET_n), .c1(c1), .c2(c2), .load(load),
    .serial_in(serial_in), .data_out(dout1), .data_valid(dv1),
    .busy(busy1), .abort(abort1)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Scoreboard monitor: pops one expectation per valid strobe.
  always @(negedge MCLK) begin
    if (abort0) ab_cnt0++;
    if (abort1) ab_cnt1++;
    if (dv0) begin
      dv_cnt0++;
      if (exp0.size() == 0) begin
        chk("lsb_unexpected_valid", 32'(dout0), 32'hdead);
      end else begin
        e0 = exp0.pop_front();
        chk("lsb_data_out", 32'(dout0), 32'(e0));
      end
    end
    if (dv1) begin
      dv_cnt1++;
      if (exp1.size() == 0) begin
        chk("msb_unexpected_valid", 32'(dout1), 32'hdead);
      end else begin
        e1 = exp1.pop_front();
        chk("msb_data_out", 32'(dout1), 32'(e1));
      end
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic drive(input logic a1, input logic a2, input logic ld, input logic s);
    c1 = a1; c2 = a2; load = ld; serial_in = s;
    tick();
  endtask

  task automatic pair(input logic b);
    drive(1'b1, 1'b0, 1'b0, b);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_pair(input logic exp_abort);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_after_load", 32'(abort0), 32'(exp_abort));
    chk("busy_after_load", 32'(busy0), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Stream bit i is val[i] (lsb order) or val[7-i] (msb order).
  task automatic push(input logic [7:0] val, input logic msb);
    exp0.push_back(msb ? rev8(val) : val);
    exp1.push_back(msb ? val : rev8(val));
  endtask

  task automatic send_bits(input logic [7:0] val, input logic msb, input int from, input int to);
    for (int i = from; i < to; i++) pair(msb ? val[7-i] : val[i]);
  endtask

  int saved;

  initial begin
    RESET_n = 1'b0; c1 = 0; c2 = 0; load = 0; serial_in = 0;
    repeat (3) tick();
    chk("rst_data_out", 32'(dout0), 32'h0);
    chk("rst_valid", 32'(dv0), 32'h0);
    chk("rst_busy", 32'({busy0, busy1}), 32'h0);
    chk("rst_abort", 32'({abort0, abort1}), 32'h0);
    RESET_n = 1'b1;
    idle(2);

    // Frame A5, lsb-first chain.
    load_pair(1'b0);
    push(8'hA5, 1'b0);
    send_bits(8'hA5, 1'b0, 0, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("busy_before_last_commit", 32'(busy0), 32'd1);
    chk("no_valid_before_last_commit", 32'(dv0), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("valid_after_last_commit", 32'(dv0), 32'd1);
    chk("busy_after_frame", 32'(busy0), 32'd0);
    idle(3);
    chk("valid_once_a5", 32'(dv_cnt0), 32'd1);

    // Frame 3C, msb-first chain.
    load_pair(1'b0);
    push(8'h3C, 1'b1);
    send_bits(8'h3C, 1'b1, 0, 8);
    idle(3);
    chk("msb_data_out_3c", 32'(dout1), 32'h3C);

    // Reload after 3 bits of FF, then a full 12 frame.
    saved = dv_cnt0;
    load_pair(1'b0);
    send_bits(8'hFF, 1'b0, 0, 3);
    load_pair(1'b1);
    idle(1);
    chk("abort_single_pulse", 32'(ab_cnt0), 32'd1);
    chk("no_valid_aborted_frame", 32'(dv_cnt0), 32'(saved));
    push(8'h12, 1'b0);
    send_bits(8'h12, 1'b0, 0, 8);
    idle(3);
    chk("data_out_after_reload", 32'(dout0), 32'h12);

    // Two c1 samples before one commit: the later one (1) wins as bit0.
    load_pair(1'b0);
    push(8'h5B, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(8'h5B, 1'b0, 1, 8);
    idle(3);
    chk("double_c1_word", 32'(dout0), 32'h5B);

    // Reset at bit 5.
    saved = dv_cnt0;
    load_pair(1'b0);
    send_bits(8'hC3, 1'b0, 0, 5);
    RESET_n = 1'b0;
    #1;
    chk("midrst_data_out", 32'(dout0), 32'h0);
    chk("midrst_busy", 32'({busy0, busy1}), 32'h0);
    chk("midrst_valid", 32'({dv0, dv1}), 32'h0);
    tick();
    RESET_n = 1'b1;
    idle(2);
    chk("midrst_no_valid", 32'(dv_cnt0), 32'(saved));
    chk("midrst_data_out_held", 32'(dout0), 32'h0);

    // Idle toggling with random serial data.
    saved = dv_cnt0;
    for (int i = 0; i < 20; i++) begin
      pair(1'($urandom_range(1, 0)));
      chk("idle_busy", 32'({busy0, busy1}), 32'h0);
    end
    idle(2);
    chk("idle_no_valid", 32'(dv_cnt0), 32'(saved));

    // c1=c2=1 right after bit3 is sampled: acts as commit, sample not retaken.
    load_pair(1'b0);
    push(8'h96, 1'b0);
    send_bits(8'h96, 1'b0, 0, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    send_bits(8'h96, 1'b0, 4, 8);
    idle(3);
    chk("c1c2_word_lsb", 32'(dout0), 32'h96);
    chk("c1c2_word_msb", 32'(dout1), 32'h69);

    idle(3);
    chk("sb_lsb_drained", 32'(exp0.size()), 32'd0);
    chk("sb_msb_drained", 32'(exp1.size()), 32'd0);
    chk("total_valid_lsb", 32'(dv_cnt0), 32'd5);
    chk("total_valid_msb", 32'(dv_cnt1), 32'd5);
    chk("total_abort_msb", 32'(ab_cnt1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
